ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read initiator for one port of the team's dual-port RAM. On a START command it sweeps a contiguous, wrapping address range, absorbs the RAM's one-cycle read latency, and emits each word as a valid/ready stream beat with TLAST on the final word. It sits between a RAM port and any stream consumer, for example a DMA drain or a debug dump path. It never writes the RAM: its write-enable and write-data outputs are tied to zero.

## Interface

Parameters:
- DATA_WIDTH, 32: RAM word width and stream data width; must be a multiple of 8.
- DEPTH, 12: number of RAM words; need not be a power of two.
- WE_WIDTH (localparam), DATA_WIDTH/8: RAM byte-enable width.
- ADDR_WIDTH (localparam), $clog2(DEPTH): address width.

Ports:
- CLK, in, 1: single clock. Everything is synchronous to its rising edge.
- RST, in, 1: synchronous, active-high reset.
- START, in, 1: command strobe, sampled only while idle.
- BASE_ADDR, in, ADDR_WIDTH: first address, sampled with START.
- LEN, in, ADDR_WIDTH+1: number of words to read, sampled with START.
- BUSY, out, 1: a command is in progress.
- DONE, out, 1: one-cycle pulse when a command completes.
- ERR, out, 1: one-cycle pulse when START is rejected.
- RAM_ADDR, out, ADDR_WIDTH: RAM port address.
- RAM_WE, out, WE_WIDTH: RAM byte write enables; constant 0.
- RAM_WDATA, out, DATA_WIDTH: RAM write data; constant 0.
- RAM_RDATA, in, DATA_WIDTH: RAM read data, valid one cycle after the address.
- M_TDATA, out, DATA_WIDTH: stream data.
- M_TVALID, out, 1: stream valid.
- M_TREADY, in, 1: stream ready.
- M_TLAST, out, 1: marks the final beat of a command.

## Operation

- **RAM model.** The RAM has a registered read with one-cycle latency: an address presented in cycle N yields data on RAM_RDATA in cycle N+1. The RAM has no read enable.
- **States.**
  - IDLE to RUN: on START with BASE_ADDR < DEPTH and LEN > 0.
  - IDLE, empty command: START with LEN == 0 pulses DONE the next cycle and stays in IDLE. No beats are produced.
  - IDLE, rejected command: START with BASE_ADDR >= DEPTH pulses ERR the next cycle and stays in IDLE.
  - RUN to DRAIN: after the final read has been issued.
  - DRAIN to IDLE: once the final beat is handshaken. DONE pulses in the first IDLE cycle.
- **Command sampling.** START is ignored in RUN and DRAIN. BASE_ADDR and LEN are sampled only with an accepted START.
- **Address generation.** The address advances by one per issued read. It wraps from DEPTH-1 to 0, not at 2^ADDR_WIDTH. LEN may exceed DEPTH; the sweep simply keeps wrapping.
- **Buffering.**
  - A 2-entry output FIFO captures RAM_RDATA in the cycle after each issued read.
  - A read issues only when (FIFO occupancy + reads in flight) < 2. The FIFO therefore never overflows and never drops data.
  - RAM_ADDR holds its last value whenever no read is issued.
- **Stream rules.** AXI-stream style:
  - Once M_TVALID is high, M_TDATA and M_TLAST hold until M_TVALID && M_TREADY.
  - M_TVALID never depends combinationally on M_TREADY.
  - M_TLAST is high only on beat LEN-1.
- **Counters.** The issue counter and the beat counter are each ADDR_WIDTH+1 bits. They are compared against the latched LEN.
- **Reset mid-operation.** Reset returns to IDLE, flushes the FIFO, and discards any in-flight read. No DONE is generated for the aborted command.

## Timing

- **Reset values.** BUSY, DONE, ERR, M_TVALID and M_TLAST are 0. RAM_ADDR is 0. M_TDATA is 0. RAM_WE and RAM_WDATA are always 0.
- **Start of a command.**
  - START is sampled at edge E0.
  - BUSY goes high and RAM_ADDR = BASE_ADDR in the cycle after E0.
  - The first word is captured at E2, so M_TVALID rises in the cycle after E2.
  - First-beat latency is therefore 2 cycles.
- **Throughput.** With M_TREADY held high, the block produces one beat per cycle, with no bubbles.
- **Back-pressure.** While M_TREADY is low, at most 2 words are buffered and issuing stalls. Issuing resumes in the cycle after the next handshake.
- **End of a command.**
  - The final handshake occurs at edge En.
  - BUSY goes low and DONE is high for exactly one cycle after En.
  - A new START is accepted in that same DONE cycle.
- **ERR and empty-command DONE.** Each is high for exactly one cycle after the START edge. BUSY stays 0.

## Test plan

1. **Basic read.** Preload words 0..11 with 0xA0+i. START with BASE_ADDR=2, LEN=4, M_TREADY=1.
   - Required: beats 0xA2, 0xA3, 0xA4, 0xA5 on consecutive cycles.
   - Required: TLAST on 0xA5, first TVALID 2 cycles after START, DONE one cycle after the final beat.
2. **Wrap-around.** BASE_ADDR=10, LEN=5.
   - Required: beats 0xAA, 0xAB, 0xA0, 0xA1, 0xA2, with TLAST only on 0xA2.
   - Required: RAM_ADDR never reaches 12.
3. **Back-pressure.** LEN=6 with M_TREADY toggled 1,0,0,1,0,1,...
   - Required: all 6 words arrive in order with none lost or duplicated.
   - Required: TDATA stays stable while stalled, and in-flight reads never exceed the free FIFO space.
4. **Degenerate commands.**
   - LEN=0: DONE pulses once with no TVALID.
   - BASE_ADDR=12: ERR pulses once, and BUSY and TVALID stay 0.
   - LEN=24 from BASE_ADDR=0: the stream is two full passes 0xA0..0xAB.
5. **START while busy.** Assert START with BASE_ADDR=0, LEN=3 during the LEN=4 command of scenario 1.
   - Required: the second START is ignored; only the 4 original beats appear and exactly one DONE pulse occurs.
6. **Reset mid-operation.** Assert RST for one cycle after 2 beats of a LEN=8 command.
   - Required: all outputs return to reset values the next cycle, no DONE pulse occurs, and no stale beat appears.
   - Required: a following command with BASE_ADDR=0, LEN=2 yields 0xA0, 0xA1 exactly.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// Command, RAM-port and stream signals of the RAM stream reader.
// The master modport is the reader's view; slave is the RAM/consumer/host side.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 12
);
  localparam int WE_WIDTH   = DATA_WIDTH / 8;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  START;
  logic [ADDR_WIDTH-1:0] BASE_ADDR;
  logic [ADDR_WIDTH:0]   LEN;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  logic [ADDR_WIDTH-1:0] RAM_ADDR;
  logic [WE_WIDTH-1:0]   RAM_WE;
  logic [DATA_WIDTH-1:0] RAM_WDATA;
  logic [DATA_WIDTH-1:0] RAM_RDATA;
  logic [DATA_WIDTH-1:0] M_TDATA;
  logic                  M_TVALID;
  logic                  M_TREADY;
  logic                  M_TLAST;

  modport master (
    input  START, BASE_ADDR, LEN, RAM_RDATA, M_TREADY,
    output BUSY, DONE, ERR, RAM_ADDR, RAM_WE, RAM_WDATA, M_TDATA, M_TVALID, M_TLAST
  );

  modport slave (
    output START, BASE_ADDR, LEN, RAM_RDATA, M_TREADY,
    input  BUSY, DONE, ERR, RAM_ADDR, RAM_WE, RAM_WDATA, M_TDATA, M_TVALID, M_TLAST
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Sweeps a wrapping RAM address range and streams the words out with TLAST on the
// final beat; the RAM's one-cycle read latency is absorbed by a 2-entry FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START; empty/rejected commands answered here
// S_RUN   | issuing reads, FIFO may be filling and draining
// S_DRAIN | all reads issued, waiting for the final beat handshake
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 12
) (
  input logic             CLK,
  input logic             RST,
  ram_stream_reader_if.master bus
);
  localparam int WE_WIDTH   = DATA_WIDTH / 8;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  issue_cnt;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  rd_pend;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  done_q;
  logic                  err_q;

  logic                  pop;
  logic                  issue;
  logic [1:0]            committed;
  logic                  last_issue;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] next_addr;

  // A read issued now lands in the FIFO next edge; a pop this edge frees a slot in time.
  assign pop        = (occ != 2'd0) && bus.M_TREADY;
  assign committed  = occ + {1'b0, rd_pend};
  assign issue      = (state == S_RUN) && ((committed != 2'd2) || pop);
  assign last_issue = (issue_cnt == len_q - CNT_WIDTH'(1));
  assign last_beat  = (beat_cnt == len_q - CNT_WIDTH'(1));
  assign next_addr  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.START) begin
            if (bus.BASE_ADDR > LAST_ADDR) begin
              err_q <= 1'b1;
            end else if (bus.LEN == '0) begin
              done_q <= 1'b1;
            end else begin
              state     <= S_RUN;
              addr_q    <= bus.BASE_ADDR;
              len_q     <= bus.LEN;
              issue_cnt <= '0;
              beat_cnt  <= '0;
            end
          end
        end
        S_RUN: begin
          if (issue && last_issue) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && last_beat) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        addr_q    <= next_addr;
        issue_cnt <= issue_cnt + CNT_WIDTH'(1);
      end
      rd_pend <= issue;

      if (rd_pend) begin
        fifo_mem[wr_ptr] <= bus.RAM_RDATA;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  assign bus.BUSY      = (state != S_IDLE);
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.RAM_ADDR  = addr_q;
  assign bus.RAM_WE    = '0;
  assign bus.RAM_WDATA = '0;
  assign bus.M_TDATA   = fifo_mem[rd_ptr];
  assign bus.M_TVALID  = (occ != 2'd0);
  assign bus.M_TLAST   = (occ != 2'd0) && last_beat;

  // WE_WIDTH only sizes the tied-off byte enables through the interface.
  logic unused_we_width;
  assign unused_we_width = (WE_WIDTH == 0);
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed, table-driven bench for ram_stream_reader against a 12-word registered RAM
// preloaded with 0xA0+i; beats are collected by a negedge monitor and compared per command.
module tb_ram_stream_reader;
  localparam int DW    = 32;
  localparam int DEPTH = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.master)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk)
    ram_q <= (int'(bus.RAM_ADDR) < DEPTH) ? mem[bus.RAM_ADDR] : 32'hDEAD_BEEF;
  assign bus.RAM_RDATA = ram_q;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // monitor state
  logic [DW-1:0] beat_q[$];
  logic          last_q[$];
  int  first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
  int  done_cnt, err_cnt, max_addr;
  bit  busy_seen, valid_seen, wr_seen, stall_q;
  logic [DW-1:0] held_data;
  logic          held_last;

  task automatic clear_mon();
    beat_q.delete();
    last_q.delete();
    first_valid_cyc = -1;
    first_beat_cyc  = -1;
    last_beat_cyc   = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    err_cnt         = 0;
    max_addr        = 0;
    busy_seen       = 0;
    valid_seen      = 0;
    wr_seen         = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.M_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.BUSY) busy_seen = 1;
      if (bus.M_TVALID) valid_seen = 1;
      if (int'(bus.RAM_ADDR) > max_addr) max_addr = int'(bus.RAM_ADDR);
      if (bus.RAM_WE != '0 || bus.RAM_WDATA != '0) wr_seen = 1;
      if (bus.DONE) begin done_cnt++; done_cyc = cyc; end
      if (bus.ERR) err_cnt++;
      if (stall_q) begin
        n_vec++;
        if (!bus.M_TVALID || bus.M_TDATA !== held_data || bus.M_TLAST !== held_last) begin
          n_bad++;
          $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, need valid=1 data=%h last=%0b",
                   bus.M_TVALID, bus.M_TDATA, bus.M_TLAST, held_data, held_last);
        end
      end
      if (bus.M_TVALID && bus.M_TREADY) begin
        beat_q.push_back(bus.M_TDATA);
        last_q.push_back(bus.M_TLAST);
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      stall_q   = bus.M_TVALID && !bus.M_TREADY;
      held_data = bus.M_TDATA;
      held_last = bus.M_TLAST;
    end else begin
      stall_q = 0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  bus.BUSY, 0);
    chk({tag, "_done"},  bus.DONE, 0);
    chk({tag, "_err"},   bus.ERR, 0);
    chk({tag, "_valid"}, bus.M_TVALID, 0);
    chk({tag, "_last"},  bus.M_TLAST, 0);
    chk({tag, "_addr"},  bus.RAM_ADDR, 0);
    chk({tag, "_tdata"}, bus.M_TDATA, 0);
    chk({tag, "_we"},    bus.RAM_WE, 0);
    chk({tag, "_wdata"}, bus.RAM_WDATA, 0);
  endtask

  typedef struct {
    int       base;
    int       len;
    bit       tog;       // toggle M_TREADY with the back-pressure pattern
    bit       poke;      // fire a second START while busy
    bit       exp_err;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  bit pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic run_vec(input vec_t v, input int idx);
    int c0;
    int k;
    int extra;
    bit ended;
    clear_mon();
    @(posedge clk); #1;
    bus.START     = 1'b1;
    bus.BASE_ADDR = 4'(v.base);
    bus.LEN       = 5'(v.len);
    bus.M_TREADY  = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    bus.START = 1'b0;
    bus.M_TREADY = v.tog ? pat[0] : 1'b1;
    ended = 0;
    extra = 0;
    for (k = 1; k < 400 && extra < 8; k++) begin
      @(posedge clk); #1;
      bus.M_TREADY = v.tog ? pat[k % 6] : 1'b1;
      if (v.poke && k == 1) begin
        bus.START = 1'b1; bus.BASE_ADDR = 4'd0; bus.LEN = 5'd3;
      end else begin
        bus.START = 1'b0;
      end
      if (done_cnt > 0 || err_cnt > 0) ended = 1;
      if (ended) extra++;
    end
    bus.M_TREADY = 1'b1;
    chk($sformatf("v%0d_terminated", idx), ended, 1);
    chk($sformatf("v%0d_wr_outputs", idx), wr_seen, 0);
    if (v.exp_err) begin
      chk($sformatf("v%0d_err_pulses", idx), err_cnt, 1);
      chk($sformatf("v%0d_done_pulses", idx), done_cnt, 0);
      chk($sformatf("v%0d_busy_seen", idx), busy_seen, 0);
      chk($sformatf("v%0d_valid_seen", idx), valid_seen, 0);
    end else begin
      chk($sformatf("v%0d_err_pulses", idx), err_cnt, 0);
      chk($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
      chk($sformatf("v%0d_beats", idx), beat_q.size(), v.len);
      chk($sformatf("v%0d_max_addr_lt12", idx), max_addr < DEPTH, 1);
      if (v.len == 0) begin
        chk($sformatf("v%0d_busy_seen", idx), busy_seen, 0);
        chk($sformatf("v%0d_valid_seen", idx), valid_seen, 0);
        chk($sformatf("v%0d_done_cyc", idx), done_cyc, c0);
      end else begin
        for (int i = 0; i < v.len && i < beat_q.size(); i++) begin
          chk($sformatf("v%0d_beat%0d_data", idx, i), beat_q[i], 32'hA0 + ((v.base + i) % DEPTH));
          chk($sformatf("v%0d_beat%0d_last", idx, i), last_q[i], (i == v.len - 1));
        end
        if (beat_q.size() > 0) begin
          chk($sformatf("v%0d_first_word", idx), beat_q[0], v.exp_first);
          chk($sformatf("v%0d_last_word", idx), beat_q[beat_q.size()-1], v.exp_last);
        end
        chk($sformatf("v%0d_first_valid_lat", idx), first_valid_cyc - c0, 2);
        chk($sformatf("v%0d_done_after_last", idx), done_cyc - last_beat_cyc, 1);
        if (!v.tog)
          chk($sformatf("v%0d_no_bubbles", idx), last_beat_cyc - first_beat_cyc, v.len - 1);
      end
    end
  endtask

  vec_t vecs [9];

  initial begin
    vec_t tail;
    int k;
    vecs[0] = '{base: 2,  len: 4,  tog: 0, poke: 0, exp_err: 0, exp_first: 32'hA2, exp_last: 32'hA5};
    vecs[1] = '{base: 10, len: 5,  tog: 0, poke: 0, exp_err: 0, exp_first: 32'hAA, exp_last: 32'hA2};
    vecs[2] = '{base: 3,  len: 6,  tog: 1, poke: 0, exp_err: 0, exp_first: 32'hA3, exp_last: 32'hA8};
    vecs[3] = '{base: 5,  len: 0,  tog: 0, poke: 0, exp_err: 0, exp_first: 32'h0,  exp_last: 32'h0};
    vecs[4] = '{base: 12, len: 3,  tog: 0, poke: 0, exp_err: 1, exp_first: 32'h0,  exp_last: 32'h0};
    vecs[5] = '{base: 0,  len: 24, tog: 0, poke: 0, exp_err: 0, exp_first: 32'hA0, exp_last: 32'hAB};
    vecs[6] = '{base: 2,  len: 4,  tog: 0, poke: 1, exp_err: 0, exp_first: 32'hA2, exp_last: 32'hA5};
    vecs[7] = '{base: 11, len: 1,  tog: 0, poke: 0, exp_err: 0, exp_first: 32'hAB, exp_last: 32'hAB};
    vecs[8] = '{base: 7,  len: 13, tog: 1, poke: 0, exp_err: 0, exp_first: 32'hA7, exp_last: 32'hA7};
    tail    = '{base: 0,  len: 2,  tog: 0, poke: 0, exp_err: 0, exp_first: 32'hA0, exp_last: 32'hA1};

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA0 + i;
    bus.START     = 1'b0;
    bus.BASE_ADDR = '0;
    bus.LEN       = '0;
    bus.M_TREADY  = 1'b1;
    stall_q       = 0;
    clear_mon();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset in the middle of a LEN=8 command after two beats.
    clear_mon();
    @(posedge clk); #1;
    bus.START = 1'b1; bus.BASE_ADDR = 4'd4; bus.LEN = 5'd8;
    @(posedge clk); #1;
    bus.START = 1'b0;
    for (k = 0; k < 50 && beat_q.size() < 2; k++) begin
      @(posedge clk); #1;
    end
    chk("midrst_two_beats_seen", beat_q.size() >= 2, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("midrst");
    clear_mon();
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_stale_beat", valid_seen, 0);
    chk("midrst_idle", busy_seen, 0);

    run_vec(tail, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
